// File: rtl/fft_pkg.sv
// Shared definitions for the post-FFT peak scanner and related post-FFT blocks.
//   - register word offsets within the peripheral block
//   - scanner FSM state encoding
//   - scan geometry (bin count, drain length)
package fft_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_IDX    = 2'd1;
  localparam logic [1:0] REG_MAG_LO = 2'd2;
  localparam logic [1:0] REG_MAG_HI = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int NBINS        = 16;
  localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/fft_mag_sq.sv
// Squared magnitude of one complex FFT bin: re^2 + im^2.
// Purely combinational.
//   re, im : signed DATA_W-bit bin components
//   mag    : unsigned 2*DATA_W-bit result. The sum cannot overflow; the
//            largest value is 2^(2*DATA_W-1), reached for re = im = most
//            negative value.
module fft_mag_sq #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0]   re,
  input  logic signed [DATA_W-1:0]   im,
  output logic        [2*DATA_W-1:0] mag
);

  logic signed [2*DATA_W-1:0] re_sq;
  logic signed [2*DATA_W-1:0] im_sq;

  assign re_sq = re * re;
  assign im_sq = im * im;
  // Each square is non-negative, so the sum is taken as unsigned to hold
  // the single extreme case 2^(2*DATA_W-1).
  assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fft_peak_scan.sv
// Post-FFT peak detector on the openMSP430 peripheral bus.
// On a start write it walks the 16 FFT bins through bin_sel, computes the
// squared magnitude of each bin and keeps the largest (lowest index on ties).
// The result is committed to read-only registers at completion, with a
// one-cycle scan_irq pulse.
//   mclk, puc_rst         : clock, asynchronous active-high reset
//   per_addr/din/en/we    : peripheral bus request (write needs we=11, read we=00)
//   per_dout              : combinational read data, 0 when not selected
//   bin_sel               : bin index to the FFT output mux
//   bin_re, bin_im        : signed bin components for bin_sel, same cycle
//   scan_irq              : completion pulse
// Registers: +0 CTRL/STAT, +1 PEAK_IDX, +2 PEAK_MAG_LO, +3 PEAK_MAG_HI.
module fft_peak_scan
  import fft_pkg::*;
#(
  parameter logic [13:0] BASE_ADDR = 14'hA0,
  parameter int          DATA_W    = 16
) (
  input  logic                     mclk,
  input  logic                     puc_rst,
  input  logic [13:0]              per_addr,
  input  logic [15:0]              per_din,
  input  logic                     per_en,
  input  logic [1:0]               per_we,
  output logic [15:0]              per_dout,
  output logic [3:0]               bin_sel,
  input  logic signed [DATA_W-1:0] bin_re,
  input  logic signed [DATA_W-1:0] bin_im,
  output logic                     scan_irq
);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [1:0]  drain_cnt;
  logic        skip_dc;
  logic        done;
  logic        irq;
  logic [3:0]  peak_idx;
  logic [31:0] peak_mag;

  logic [13:0] offset;
  logic        in_range;
  logic        wr_ctrl;
  logic        rd_en;
  logic        busy;
  logic        start_acc;
  logic        unused_din;

  assign offset    = per_addr - BASE_ADDR;
  assign in_range  = (offset < 14'd4);
  assign wr_ctrl   = per_en && (per_we == 2'b11) && (offset == 14'(REG_CTRL));
  assign rd_en     = per_en && (per_we == 2'b00) && in_range;
  assign busy      = (state != ST_IDLE);
  assign start_acc = wr_ctrl && per_din[0] && !busy;
  assign unused_din = ^per_din[15:2];

  assign bin_sel  = cnt;
  assign scan_irq = irq;

  // Stage 1: register the bin presented on the mux
  logic signed [DATA_W-1:0] re_p1;
  logic signed [DATA_W-1:0] im_p1;
  logic [3:0]               idx_p1;
  logic                     vld_p1;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      re_p1  <= '0;
      im_p1  <= '0;
      idx_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      re_p1  <= bin_re;
      im_p1  <= bin_im;
      idx_p1 <= cnt;
      // With skip_dc the DC bin still takes its slot, it just never competes.
      vld_p1 <= (state == ST_SCAN) && !(skip_dc && (cnt == 4'd0));
    end
  end

  // Stage 2: magnitude and running maximum
  logic [2*DATA_W-1:0] mag_p1;
  logic [31:0]         best_mag_p2;
  logic [3:0]          best_idx_p2;

  fft_mag_sq #(.DATA_W(DATA_W)) u_mag_sq (
    .re  (re_p1),
    .im  (im_p1),
    .mag (mag_p1)
  );

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      best_mag_p2 <= '0;
      best_idx_p2 <= '0;
    end else if (start_acc) begin
      best_mag_p2 <= '0;
      best_idx_p2 <= per_din[1] ? 4'd1 : 4'd0;
    end else if (vld_p1 && (32'(mag_p1) > best_mag_p2)) begin
      // Strict compare: an equal later bin never displaces an earlier one.
      best_mag_p2 <= 32'(mag_p1);
      best_idx_p2 <= idx_p1;
    end
  end

  // Control FSM, committed results and bus-visible status
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      drain_cnt <= '0;
      skip_dc   <= 1'b0;
      done      <= 1'b0;
      irq       <= 1'b0;
      peak_idx  <= '0;
      peak_mag  <= '0;
    end else begin
      irq <= 1'b0;
      // CTRL writes while a scan runs are dropped entirely so the scan's
      // skip_dc setting stays consistent.
      if (wr_ctrl && !busy) begin
        skip_dc <= per_din[1];
      end
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            state <= ST_SCAN;
            cnt   <= '0;
            done  <= 1'b0;
          end
        end
        ST_SCAN: begin
          // cnt wraps back to 0 after the last bin, which is the idle value.
          cnt <= cnt + 4'd1;
          if (cnt == 4'(NBINS - 1)) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          // Two drain cycles let the last bin pass stage 1 and stage 2.
          if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
            state    <= ST_IDLE;
            done     <= 1'b1;
            irq      <= 1'b1;
            peak_idx <= best_idx_p2;
            peak_mag <= best_mag_p2;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    per_dout = 16'h0000;
    if (rd_en) begin
      case (offset[1:0])
        REG_CTRL:   per_dout = {13'd0, skip_dc, done, busy};
        REG_IDX:    per_dout = {12'd0, peak_idx};
        REG_MAG_LO: per_dout = peak_mag[15:0];
        REG_MAG_HI: per_dout = peak_mag[31:16];
        default:    per_dout = 16'h0000;
      endcase
    end
  end

endmodule

// File: doc/fft_peak_scan.md
# fft_peak_scan

Post-FFT peak detector on the openMSP430 peripheral bus, directly downstream of the 16-point FFT peripheral. On software command it walks the 16 output bins through a bin-select port, computes the squared magnitude re²+im² of each bin, and records the largest bin and its magnitude. Results are exposed as read-only peripheral registers, and a one-cycle interrupt pulse marks completion.

## Interface
Parameters:
- BASE_ADDR, 14'hA0, word address of the register block; occupies BASE_ADDR..BASE_ADDR+3.

Ports:
- mclk  in  1  system clock
- puc_rst  in  1  reset, asynchronous, active-high
- per_addr  in  14  peripheral word address
- per_din  in  16  write data
- per_en  in  1  active bus cycle enable
- per_we  in  2  byte write enables; a write requires 2'b11, a read requires 2'b00
- per_dout  out  16  read data; 0 when not selected
- bin_sel  out  4  FFT bin index presented to the FFT output mux
- bin_re  in  16  signed real part of bin bin_sel, same cycle
- bin_im  in  16  signed imaginary part of bin bin_sel, same cycle
- scan_irq  out  1  one-cycle pulse on scan completion

## Operation
- Registers, at offset from BASE_ADDR:
  - +0 CTRL/STAT. Write: bit0 start, bit1 skip_dc (latched on every write). Read: bit0 busy, bit1 done, bit2 skip_dc, other bits 0.
  - +1 PEAK_IDX: [3:0] = index, other bits 0.
  - +2 PEAK_MAG_LO: mag[15:0].
  - +3 PEAK_MAG_HI: mag[31:16].
- per_dout is combinational.
  - It returns 0 when per_en=0, when per_we≠0, or for an unmapped address.
  - Writes to +1..+3 are ignored.
- FSM states: IDLE, SCAN, DRAIN.
  - IDLE → SCAN on a start write. A start written while busy is ignored and does not change skip_dc.
  - SCAN: bin_sel increments 0..15, one bin per cycle. After bin 15 the FSM goes to DRAIN.
  - DRAIN lasts 2 cycles, then returns to IDLE. At that point the committed registers are loaded, done=1 and scan_irq=1.
- Pipeline:
  - Stage 1 registers {bin_re, bin_im, bin_sel, valid}.
  - Stage 2 computes mag = re² + im² and compares it.
  - Squares are signed 16×16 products; their sum is an unsigned 32-bit value that never overflows. The maximum is 0x80000000, for re=im=0x8000.
- Working best value:
  - On start: best_mag=0 and best_idx = skip_dc ? 1 : 0.
  - On each valid compare: update only if mag > best_mag (strict). Ties therefore keep the lowest index.
- skip_dc=1 leaves timing unchanged; bin 0 is captured with valid=0.
- Committed registers (PEAK_*) change only at completion. Reads during a scan return the previous result.
- A start write clears done.
- In IDLE, bin_sel holds 0.

## Timing
- Reset values: all outputs 0, all registers 0, FSM in IDLE. This includes skip_dc, done, busy, PEAK_* and bin_sel.
- Edge numbering, with E0 the edge that samples the start write:
  - E0: busy=1 and bin_sel=0.
  - E1..E16: stage 1 captures bins 0..15.
  - E2..E17: bins 0..15 are compared.
  - E18: commit, busy=0, done=1, scan_irq=1 for exactly one cycle.
- Total latency from start to done is 18 cycles.
- Back-to-back: a start accepted in the first IDLE cycle after E18 begins a new scan normally.
- puc_rst during a scan aborts it immediately: IDLE, all registers 0, no scan_irq.
- A start write and a read of CTRL in the same cycle are not possible (per_we differs); nothing special is required.

## Structure
- fft_pkg holds:
  - register offset constants (CTRL=0, IDX=1, MAG_LO=2, MAG_HI=3);
  - FSM state encoding;
  - NBINS=16 and DRAIN_CYCLES=2.
- Sub-module fft_mag_sq: combinational; signed 16-bit re and im in, unsigned 32-bit re²+im² out. It is reusable by other post-FFT blocks.

## Test plan
- Reset: after puc_rst every register read returns 0x0000, bin_sel=0 and scan_irq=0. A start followed by a write of 0 to CTRL leaves skip_dc=0.
- Single peak: bin 5 = (re 0x0100, im 0xFF00), all other bins 0. Start. Required response:
  - scan_irq is high exactly 18 cycles after the start edge;
  - IDX=5, MAG_LO=0x0000, MAG_HI=0x0002;
  - STAT=0x0002.
- Tie and extreme values:
  - bins 3 and 9 both = (0x0003, 0x0004) → IDX=3, MAG=0x00000019;
  - bin 7 = (0x8000, 0x8000) → IDX=7, MAG_HI=0x8000, MAG_LO=0x0000.
- skip_dc: bin 0 = (0x7FFF, 0), bin 2 = (1, 0), start with skip_dc=1 → IDX=2, MAG=1. With all bins zero and skip_dc=1 → IDX=1, MAG=0.
- Busy behaviour:
  - a second start at E5 is ignored: one irq at E18, and STAT reads 0x0001 during the scan;
  - PEAK_* reads return the previous scan's values until E18.
- Reset mid-scan: assert puc_rst at E9 → STAT=0, PEAK_*=0, bin_sel=0, no irq. A fresh start afterwards completes normally in 18 cycles.
